// File: rtl/presc_timer.sv
// Prescaled up/down counter with free-run, auto-reload, one-shot and saturate modes; cnt/tick/tc/done update one clock after the step.
// No backpressure: en freezes prescaler and counter, and load takes priority over counting.
module presc_timer #(
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] presc_div,
    input  logic                   dir,
    input  logic [1:0]             mode,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    input  logic [WIDTH-1:0]       reload_val,
    input  logic [WIDTH-1:0]       cmp_val,
    output logic [WIDTH-1:0]       cnt,
    output logic                   tick,
    output logic                   tc,
    output logic                   cmp_match,
    output logic                   done
);

    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_RELOAD = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_SAT    = 2'b11;

    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic                   tick_q, tick_d;
    logic                   tc_q, tc_d;
    logic                   done_q, done_d;

    logic                   step;
    logic [WIDTH-1:0]       term_val;
    logic [WIDTH-1:0]       cnt_next;
    logic                   at_term;

    // >= rather than == so that shrinking presc_div mid-count steps immediately
    assign step     = en && (pcnt_q >= presc_div);
    assign term_val = dir ? '0 : '1;
    assign cnt_next = dir ? cnt_q - 1'b1 : cnt_q + 1'b1;
    assign at_term  = (cnt_q == term_val);

    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (load) begin
            cnt_d  = load_val;
            pcnt_d = '0;
            done_d = 1'b0;
        end else if (step) begin
            pcnt_d = '0;
            tick_d = 1'b1;
            case (mode)
                MODE_FREE: begin
                    cnt_d = cnt_next;
                    tc_d  = (cnt_next == term_val);
                end
                MODE_RELOAD: begin
                    if (at_term) begin
                        cnt_d = reload_val;
                        tc_d  = (reload_val == term_val);
                    end else begin
                        cnt_d = cnt_next;
                        tc_d  = (cnt_next == term_val);
                    end
                end
                MODE_ONESHOT: begin
                    if (!done_q) begin
                        if (at_term) begin
                            done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_next;
                            if (cnt_next == term_val) begin
                                done_d = 1'b1;
                                tc_d   = 1'b1;
                            end
                        end
                    end
                end
                MODE_SAT: begin
                    if (!at_term) begin
                        cnt_d = cnt_next;
                        tc_d  = (cnt_next == term_val);
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end else if (en) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign cnt       = cnt_q;
    assign tick      = tick_q;
    assign tc        = tc_q;
    assign done      = done_q;
    assign cmp_match = (cnt_q == cmp_val);

endmodule

// File: tb/tb_presc_timer.sv
// Directed self-checking bench for presc_timer (WIDTH=8, PRESC_WIDTH=8).
module tb_presc_timer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] presc_div;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] reload_val;
    logic [7:0] cmp_val;
    logic [7:0] cnt;
    logic       tick;
    logic       tc;
    logic       cmp_match;
    logic       done;

    int checks;
    int errors;

    presc_timer #(.WIDTH(8), .PRESC_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .presc_div  (presc_div),
        .dir        (dir),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .reload_val (reload_val),
        .cmp_val    (cmp_val),
        .cnt        (cnt),
        .tick       (tick),
        .tc         (tc),
        .cmp_match  (cmp_match),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        clks(1);
        load     = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        en         = 1'b0;
        presc_div  = 8'd7;
        dir        = 1'b0;
        mode       = 2'b00;
        load       = 1'b0;
        load_val   = 8'd0;
        reload_val = 8'd0;
        cmp_val    = 8'h40;
        clks(2);
        check("rst_cnt",  32'(cnt),  0);
        check("rst_tick", 32'(tick), 0);
        check("rst_tc",   32'(tc),   0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        en  = 1'b1;

        // free-run up, divide by 8
        clks(7);
        check("fr_pre_cnt",  32'(cnt),  0);
        check("fr_pre_tick", 32'(tick), 0);
        clks(1);
        check("fr_first_cnt",  32'(cnt),  1);
        check("fr_first_tick", 32'(tick), 1);
        clks(2032);
        check("fr_255_cnt", 32'(cnt), 255);
        check("fr_255_tc",  32'(tc),  1);
        clks(1);
        check("fr_tc_pulse", 32'(tc),   0);
        check("fr_tick_gap", 32'(tick), 0);
        clks(7);
        check("fr_wrap_cnt",  32'(cnt),  0);
        check("fr_wrap_tick", 32'(tick), 1);
        check("fr_wrap_tc",   32'(tc),   0);

        // auto-reload down from 3, reload 9, tick every cycle
        mode       = 2'b01;
        dir        = 1'b1;
        reload_val = 8'd9;
        presc_div  = 8'd0;
        do_load(8'd3);
        check("ar_load_cnt",  32'(cnt),  3);
        check("ar_load_tick", 32'(tick), 0);
        exp_cnt = 3;
        for (int i = 0; i < 14; i++) begin
            exp_cnt = (exp_cnt == 0) ? 9 : exp_cnt - 1;
            clks(1);
            check("ar_cnt", 32'(cnt), exp_cnt);
            check("ar_tc",  32'(tc),  (exp_cnt == 0) ? 1 : 0);
        end

        // one-shot up from 250, divide by 2
        mode      = 2'b10;
        dir       = 1'b0;
        presc_div = 8'd1;
        do_load(8'd250);
        clks(9);
        check("os_254_cnt",  32'(cnt),  254);
        check("os_254_done", 32'(done), 0);
        clks(1);
        check("os_255_cnt",  32'(cnt),  255);
        check("os_255_done", 32'(done), 1);
        check("os_255_tc",   32'(tc),   1);
        clks(2);
        check("os_hold_cnt",  32'(cnt),  255);
        check("os_hold_tick", 32'(tick), 1);
        check("os_hold_tc",   32'(tc),   0);
        check("os_hold_done", 32'(done), 1);
        do_load(8'd10);
        check("os_ld_done", 32'(done), 0);
        check("os_ld_cnt",  32'(cnt),  10);
        do_load(8'd255);
        check("ld_term_tc",   32'(tc),   0);
        check("ld_term_tick", 32'(tick), 0);

        // saturate up, then reverse
        mode      = 2'b11;
        presc_div = 8'd0;
        do_load(8'd253);
        clks(1);
        check("sat_254", 32'(cnt), 254);
        check("sat_254_tc", 32'(tc), 0);
        clks(1);
        check("sat_255", 32'(cnt), 255);
        check("sat_255_tc", 32'(tc), 1);
        clks(1);
        check("sat_hold1", 32'(cnt), 255);
        check("sat_hold1_tc", 32'(tc), 0);
        clks(1);
        check("sat_hold2", 32'(cnt), 255);
        check("sat_hold2_tc", 32'(tc), 0);
        dir = 1'b1;
        clks(1);
        check("sat_rev_cnt", 32'(cnt), 254);
        check("sat_rev_tc",  32'(tc),  0);

        // prescaler shrink and enable freeze
        mode      = 2'b00;
        dir       = 1'b0;
        presc_div = 8'd15;
        do_load(8'd0);
        clks(10);
        check("pr_wait_cnt", 32'(cnt), 0);
        presc_div = 8'd4;
        clks(1);
        check("pr_shrink_cnt",  32'(cnt),  1);
        check("pr_shrink_tick", 32'(tick), 1);
        clks(2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clks(1);
            check("en_frz_cnt",  32'(cnt),  1);
            check("en_frz_tick", 32'(tick), 0);
        end
        en = 1'b1;
        clks(2);
        check("en_res_cnt", 32'(cnt), 1);
        clks(1);
        check("en_res_step", 32'(cnt), 2);
        check("en_res_tick", 32'(tick), 1);

        // compare match, then reset with load pending
        presc_div = 8'd0;
        do_load(8'h3E);
        check("cmp_3e", 32'(cmp_match), 0);
        clks(1);
        check("cmp_3f", 32'(cmp_match), 0);
        clks(1);
        check("cmp_40", 32'(cmp_match), 1);
        check("cmp_40_cnt", 32'(cnt), 32'h40);
        clks(1);
        check("cmp_41", 32'(cmp_match), 0);
        rst      = 1'b1;
        load     = 1'b1;
        load_val = 8'h55;
        clks(1);
        check("rst2_cnt",  32'(cnt),  0);
        check("rst2_tick", 32'(tick), 0);
        check("rst2_tc",   32'(tc),   0);
        check("rst2_done", 32'(done), 0);
        rst  = 1'b0;
        load = 1'b0;
        clks(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/presc_timer.md
Name: presc_timer

Overview:
- Parametrised prescaled counter/timer: the next generation of the team's fixed-prescaler 8-bit strobe counter.
- Adds runtime prescaler divisor, generic width, up/down count, four count modes, synchronous load, compare match, terminal-count pulse and one-shot done flag.
- Used as the general timebase/event timer feeding PWM, timeout and sampling blocks.

Parameters:
- WIDTH, 8, counter width in bits.
- PRESC_WIDTH, 8, prescaler divisor width in bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable; low freezes prescaler and counter
- presc_div  input  PRESC_WIDTH  divide ratio minus one (tick every presc_div+1 enabled cycles)
- dir  input  1  0 = up, 1 = down
- mode  input  2  00 free-run wrap, 01 auto-reload, 10 one-shot, 11 saturate
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  value loaded on load
- reload_val  input  WIDTH  value used in auto-reload mode
- cmp_val  input  WIDTH  compare value
- cnt  output  WIDTH  counter value (registered)
- tick  output  1  prescaler strobe, registered; high the cycle cnt shows the post-tick value
- tc  output  1  terminal-count pulse, registered, one cycle
- cmp_match  output  1  combinational (cnt == cmp_val)
- done  output  1  one-shot finished flag, registered level

Behaviour:
- Reset: cnt=0, internal pcnt=0, tick=0, tc=0, done=0. Reset has priority over all other inputs, including mid-count.
- Terminal value T: all-ones when dir=0, zero when dir=1.
- Prescaler:
  - Internal step = en & (pcnt >= presc_div). On step, pcnt<=0; otherwise, if en=1, pcnt<=pcnt+1.
  - The >= comparison means that shrinking presc_div mid-count produces a step on the next enabled cycle.
  - presc_div=0 gives a step on every enabled cycle.
  - en=0 holds pcnt, cnt and done; tick and tc are 0.
- tick: registered copy of step. It is high for one cycle together with the updated cnt. Latency is one clock from the step cycle.
- Count update on a step (no load):
  - Mode 00: cnt±1 modulo 2^WIDTH.
  - Mode 01: if cnt==T then cnt<=reload_val, else cnt±1.
  - Mode 10: if done=1, hold. If cnt==T, hold and set done=1. Otherwise cnt±1; if the result equals T, done<=1 on the same edge.
  - Mode 11: if cnt==T, hold, else cnt±1. Reversing dir resumes counting away from the old terminal.
- tc:
  - tc<=1 for one cycle when a step leaves cnt equal to T and the pre-step cnt was not T.
  - Exception: in mode 01, tc also pulses when reload_val==T and the reload occurs.
  - Saturate and one-shot do not re-pulse while holding.
- load:
  - Priority over step: cnt<=load_val, pcnt<=0, done<=0.
  - tick and tc are not asserted for that cycle, even if load_val==T.
  - load is honoured regardless of en.
- Changes to mode and dir are sampled on the next step edge only. No state is lost on a change.
- cmp_match follows cnt combinationally. It is valid in the same cycle as cnt and is independent of en.

Test Plan:
- WIDTH=8, presc_div=7, mode=00, dir=0, en=1 after reset: tick every 8 clocks; cnt 0→1 on first tick at clock 8; cnt reaches 255 after 2040 clocks with tc=1 that cycle; next tick cnt=0, tc=0.
- Auto-reload: mode=01, dir=1, reload_val=9, presc_div=0, load with load_val=3: cnt 3,2,1,0 with tc at 0, then 9,8,… ; tc every 10 ticks.
- One-shot: mode=10, dir=0, load_val=250, presc_div=1: cnt reaches 255 after 10 clocks; done=1 and tc=1 on the same cycle; further ticks keep cnt=255, tc=0; load clears done.
- Saturate plus reversal: mode=11, dir=0, cnt at 255 for 3 ticks (single tc); set dir=1 → next tick cnt=254, no tc.
- en/presc change: presc_div=15 with pcnt=10; change to 4 → step on next enabled cycle. Drop en for 5 cycles → cnt and pcnt frozen, tick=0.
- Compare and reset: cmp_val=0x40 → cmp_match high exactly while cnt=0x40. Assert rst mid-count with load=1 → all outputs 0 next cycle.
